matrix_buffer: RTL and testbench

MATRIX_BUFFER -- requirements
Module: matrix_buffer

---
 rtl/matrix_buffer.sv | 186 ++++++++++++++++++
 tb/tb_matrix_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_buffer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_buffer
// Purpose  : LINES x DEPTH element store streamed out diagonally (skewed) to
//            feed a systolic array; optional transpose via
//            MATRIX_BUFFER_TRANSPOSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(LINES)-1:0]      wr_line,
    input  logic [$clog2(DEPTH)-1:0]      wr_elem,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          start,
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    input  logic                          transpose,
`endif
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic                          wr_err,
    output logic [LINES-1:0]              stream_valid,
    output logic [LINES*DATA_WIDTH-1:0]   stream_data
);

    localparam int LW = $clog2(LINES);
    localparam int EW = $clog2(DEPTH);
    localparam int TW = $clog2(DEPTH + LINES - 1);
    localparam logic [TW-1:0] C_T_LAST = TW'(DEPTH + LINES - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TW-1:0]         r_t;
    logic [TW-1:0]         w_t_nxt;
    logic                  r_wr_err;
    logic                  w_line_ok;
    logic                  w_elem_ok;
    logic                  w_wr_in_range;
    logic [DATA_WIDTH-1:0] r_mem [LINES][DEPTH];

    // ------------------------------------------------------------------
    // Write address range check (only meaningful for non-power-of-2 sizes)
    // ------------------------------------------------------------------
    if ((1 << LW) == LINES) begin : g_line_pow2
        assign w_line_ok = 1'b1;
    end else begin : g_line_npow2
        assign w_line_ok = (wr_line < LW'(LINES));
    end

    if ((1 << EW) == DEPTH) begin : g_elem_pow2
        assign w_elem_ok = 1'b1;
    end else begin : g_elem_npow2
        assign w_elem_ok = (wr_elem < EW'(DEPTH));
    end

    assign w_wr_in_range = w_line_ok && w_elem_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = ST_STREAM;
                    w_t_nxt     = '0;
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (r_t == C_T_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
                w_t_nxt     = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: writes only land while idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LINES; l++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[l][e] <= '0;
                end
            end
        end else if (wr_en && w_wr_in_range && (r_state == ST_IDLE)) begin
            r_mem[wr_line][wr_elem] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && w_wr_in_range && (r_state != ST_IDLE);
        end
    end

    assign wr_err = r_wr_err;

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    logic r_transpose;

    if (LINES != DEPTH) begin : g_transpose_check
        $error("matrix_buffer: transpose requires LINES == DEPTH");
    end

    // Latched on the start edge so the whole stream uses one orientation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_transpose <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_transpose <= transpose;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Skewed read-out: line l lags line 0 by l cycles
    // ------------------------------------------------------------------
    for (genvar gl = 0; gl < LINES; gl++) begin : g_line
        logic [TW:0]           w_off;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] w_elem;

        // Extra MSB acts as the borrow flag for t < l
        assign w_off = {1'b0, r_t} - (TW+1)'(gl);
        assign w_hit = (r_state == ST_STREAM) && !w_off[TW]
                       && (w_off[TW-1:0] < TW'(DEPTH));

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
        assign w_elem = r_transpose ? r_mem[w_off[LW-1:0]][gl]
                                    : r_mem[gl][w_off[EW-1:0]];
`else
        assign w_elem = r_mem[gl][w_off[EW-1:0]];
`endif

        assign stream_valid[gl]                          = w_hit;
        assign stream_data[gl*DATA_WIDTH +: DATA_WIDTH]  = w_hit ? w_elem : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_buffer
// Purpose  : Scoreboard bench for matrix_buffer (default 4x4, 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_buffer;

    localparam int DW    = 8;
    localparam int LINES = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_line;
    logic [1:0]    wr_elem;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          ready;
    logic          busy;
    logic          done;
    logic          wr_err;
    logic [3:0]    stream_valid;
    logic [31:0]   stream_data;
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    logic          transpose;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        done;
    } exp_t;

    exp_t          exp_q [$];
    exp_t          mon_rec;
    logic [DW-1:0] exp_mem [LINES][DEPTH];

    matrix_buffer #(
        .DATA_WIDTH (DW),
        .LINES      (LINES),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_line      (wr_line),
        .wr_elem      (wr_elem),
        .wr_data      (wr_data),
        .start        (start),
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
        .transpose    (transpose),
`endif
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .wr_err       (wr_err),
        .stream_valid (stream_valid),
        .stream_data  (stream_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  32'(ready),        32'd1);
        check({tag, "_busy"},   32'(busy),         32'd0);
        check({tag, "_done"},   32'(done),         32'd0);
        check({tag, "_wr_err"}, 32'(wr_err),       32'd0);
        check({tag, "_valid"},  32'(stream_valid), 32'd0);
        check({tag, "_data"},   stream_data,       32'd0);
    endtask

    // Expected per-cycle outputs while busy: n stream cycles, then optional DONE
    function automatic void push_stream(input bit tr, input int n, input bit with_done);
        exp_t r;
        for (int t = 0; t < n; t++) begin
            r = '0;
            for (int l = 0; l < LINES; l++) begin
                int e;
                e = t - l;
                if (e >= 0 && e < DEPTH) begin
                    r.valid[l]       = 1'b1;
                    r.data[l*DW +: DW] = tr ? exp_mem[e][l] : exp_mem[l][e];
                end
            end
            exp_q.push_back(r);
        end
        if (with_done) begin
            r      = '0;
            r.done = 1'b1;
            exp_q.push_back(r);
        end
    endfunction

    // Called just after a rising edge; returns just after the next one
    task automatic do_write(input int l, input int e, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_line = 2'(l);
        wr_elem = 2'(e);
        wr_data = d;
        exp_mem[l][e] = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic run_stream(input bit tr);
        push_stream(tr, 7, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("ready_after_stream", 32'(ready), 32'd1);
    endtask

    // Monitor: every busy cycle must match the next scoreboard entry
    always @(negedge clk) begin
        if (busy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: valid=%b data=%h done=%b with no expectation queued",
                         stream_valid, stream_data, done);
            end else begin
                mon_rec = exp_q.pop_front();
                if (stream_valid !== mon_rec.valid || stream_data !== mon_rec.data
                    || done !== mon_rec.done) begin
                    errors++;
                    $display("FAIL stream_cycle: got valid=%b data=%h done=%b, required valid=%b data=%h done=%b",
                             stream_valid, stream_data, done, mon_rec.valid, mon_rec.data, mon_rec.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_line = '0;
        wr_elem = '0;
        wr_data = '0;
        start   = 1'b0;
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
        transpose = 1'b0;
`endif
        for (int l = 0; l < LINES; l++)
            for (int e = 0; e < DEPTH; e++)
                exp_mem[l][e] = '0;

        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Diagonal stream of mem[l][e] = 16*l + e
        for (int l = 0; l < LINES; l++)
            for (int e = 0; e < DEPTH; e++)
                do_write(l, e, 8'(16*l + e));
        check("idle_write_no_err", 32'(wr_err), 32'd0);
        run_stream(1'b0);

        // Write attempt during STREAM at t=2 is rejected
        push_stream(1'b0, 7, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_line = 2'd2;
        wr_elem = 2'd1;
        wr_data = 8'hAA;
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(negedge clk);
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("wr_err_one_cycle", 32'(wr_err), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("ready_after_rejected_write", 32'(ready), 32'd1);
        run_stream(1'b0);

        // Write and start on the same edge
        wr_en   = 1'b1;
        wr_line = 2'd1;
        wr_elem = 2'd0;
        wr_data = 8'h5C;
        exp_mem[1][0] = 8'h5C;
        run_stream(1'b0);

        // start held high: back-to-back streams, DONE + IDLE between them
        push_stream(1'b0, 7, 1'b1);
        push_stream(1'b0, 7, 1'b1);
        push_stream(1'b0, 7, 1'b1);
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("held_start_ready_k%0d", k), 32'(ready), 32'((k % 9) == 8));
        end
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("held_start_ready_end", 32'(ready), 32'd1);
        check("held_start_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
        transpose = 1'b1;
        push_stream(1'b1, 7, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        transpose = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("transpose_ready_after", 32'(ready), 32'd1);
`endif

        // Reset at t=3 aborts the stream without a done pulse
        push_stream(1'b0, 3, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        #1 rst = 1'b0;
        for (int l = 0; l < LINES; l++)
            for (int e = 0; e < DEPTH; e++)
                exp_mem[l][e] = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        run_stream(1'b0);

        check("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
